// File: rtl/psc_packet_builder.sv
// Streams fixed 10-byte packets (SOP, status, addr, data, CRC-8, EOP) over a
// valid/ready byte interface, substituting a one-deep pending trigger for the idle packet.
module psc_packet_builder #(
  parameter logic [15:0] IDLE_ADDR = 16'h0040,
  parameter logic [7:0]  SOP       = 8'h3C,
  parameter logic [7:0]  EOP       = 8'hBC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        trig_req,
  input  logic [15:0] trig_addr,
  input  logic [31:0] trig_data,
  input  logic [7:0]  status,
  input  logic        byte_ready,
  output logic        byte_valid,
  output logic [7:0]  byte_out,
  output logic        byte_k,
  output logic        trig_ack,
  output logic        overrun
);

  typedef enum logic [1:0] {
    HALT = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  idx;
  logic        pending;
  logic [15:0] pend_addr;
  logic [31:0] pend_data;
  logic [7:0]  pkt_status;
  logic [15:0] pkt_addr;
  logic [31:0] pkt_data;
  logic [7:0]  crc;

  logic        xfer;
  logic        last_xfer;
  logic        enter_load;
  logic        trig_accept;
  logic        trig_drop;
  logic [3:0]  idx_nxt;
  logic [7:0]  crc_upd;
  logic [7:0]  next_byte;

  // CRC-8 poly 0x07, MSB-first, one whole byte per call.
  function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign xfer        = byte_valid && byte_ready;
  assign last_xfer   = (state == SEND) && xfer && (idx == 4'd9);
  assign enter_load  = enable && ((state == HALT) || last_xfer);
  // A request arriving in LOAD may refill the slot that LOAD is emptying.
  assign trig_accept = trig_req && (!pending || (state == LOAD));
  assign trig_drop   = trig_req && pending && (state != LOAD);
  assign idx_nxt     = idx + 4'd1;
  assign crc_upd     = crc8_byte(crc, byte_out);

  always_comb begin
    next_byte = 8'h00;
    case (idx_nxt)
      4'd1:    next_byte = pkt_status;
      4'd2:    next_byte = pkt_addr[7:0];
      4'd3:    next_byte = pkt_addr[15:8];
      4'd4:    next_byte = pkt_data[31:24];
      4'd5:    next_byte = pkt_data[23:16];
      4'd6:    next_byte = pkt_data[15:8];
      4'd7:    next_byte = pkt_data[7:0];
      4'd8:    next_byte = crc_upd;
      4'd9:    next_byte = EOP;
      default: next_byte = 8'h00;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HALT;
      idx        <= 4'd0;
      pending    <= 1'b0;
      pend_addr  <= 16'h0000;
      pend_data  <= 32'h0000_0000;
      pkt_status <= 8'h00;
      pkt_addr   <= 16'h0000;
      pkt_data   <= 32'h0000_0000;
      crc        <= 8'h00;
      byte_valid <= 1'b0;
      byte_out   <= 8'h00;
      byte_k     <= 1'b0;
      trig_ack   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Ack is registered on entry so it is high during the LOAD that consumes the trigger.
      trig_ack <= enter_load && (pending || trig_req);

      if (trig_drop) overrun <= 1'b1;

      if (trig_accept) begin
        pending   <= 1'b1;
        pend_addr <= trig_addr;
        pend_data <= trig_data;
      end else if (state == LOAD) begin
        pending <= 1'b0;
      end

      case (state)
        HALT: begin
          byte_valid <= 1'b0;
          if (enable) state <= LOAD;
        end
        LOAD: begin
          pkt_status <= status;
          if (pending) begin
            pkt_addr <= pend_addr;
            pkt_data <= pend_data;
          end else begin
            pkt_addr <= IDLE_ADDR;
            pkt_data <= 32'h0000_0000;
          end
          crc        <= 8'h00;
          idx        <= 4'd0;
          byte_out   <= SOP;
          byte_k     <= 1'b1;
          byte_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (xfer) begin
            if (idx == 4'd9) begin
              idx        <= 4'd0;
              byte_valid <= 1'b0;
              byte_out   <= 8'h00;
              byte_k     <= 1'b0;
              state      <= enable ? LOAD : HALT;
            end else begin
              if ((idx >= 4'd1) && (idx <= 4'd7)) crc <= crc_upd;
              idx      <= idx_nxt;
              byte_out <= next_byte;
              byte_k   <= (idx_nxt == 4'd9);
            end
          end
        end
        default: begin
          state      <= HALT;
          byte_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
